// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32 datapath.
// State-decoded strobes are registered from the next state so they change
// cleanly on the clock edge; only the strobes that must react to MemReady
// (or Opcode) in the current cycle are formed combinationally.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Opcode,
  input  logic       MemReady,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       Retire,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JAL    = 4'd9,
    IEXEC  = 4'd10
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic [1:0] memto_reg;
    logic       reg_write;
    logic       retire;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  logic   opcode_legal;
  logic   in_fetch;
  logic   in_memwr;

  // Unconditional strobes for a given state; the MemReady-qualified ones
  // (fetch IR/PC write, store retire) are added outside the register.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'd1;
      end
      DECODE: c.alu_src_b = 2'd2;
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEMWB: begin
        c.reg_write = 1'b1;
        c.memto_reg = 2'd1;
        c.retire    = 1'b1;
      end
      MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'd2;
      end
      IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      RWB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'd1;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'd1;
        c.retire        = 1'b1;
      end
      JAL: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'd2;
        c.reg_write = 1'b1;
        c.memto_reg = 2'd2;
        c.retire    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Recognise the opcodes this datapath can execute
  always_comb begin
    opcode_legal = 1'b0;
    case (Opcode)
      OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  end

  // Next-state selection; MemReady only matters in the three memory states
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Opcode)
          OP_RTYPE:          state_d = EXEC;
          OP_IALU:           state_d = IEXEC;
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default:           state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (Opcode == OP_LOAD) ? MEMRD : MEMWR;
      MEMRD:  state_d = MemReady ? MEMWB : MEMRD;
      MEMWR:  state_d = MemReady ? FETCH : MEMWR;
      EXEC:   state_d = RWB;
      IEXEC:  state_d = RWB;
      default: state_d = FETCH;
    endcase
  end

  // State register and registered strobes; reset lands on FETCH values at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ctrl_q  <= decode(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  assign in_fetch = (state_q == FETCH);
  assign in_memwr = (state_q == MEMWR);

  assign ALUOp       = ctrl_q.alu_op;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign PCSource    = ctrl_q.pc_source;
  assign MemtoReg    = ctrl_q.memto_reg;
  assign RegWrite    = ctrl_q.reg_write;
  assign IRWrite     = rst_n & in_fetch & MemReady;
  assign PCWrite     = ctrl_q.pc_write | IRWrite;
  assign Retire      = ctrl_q.retire | (rst_n & in_memwr & MemReady);
  assign IllegalOp   = rst_n & (state_q == DECODE) & ~opcode_legal;
  assign State       = state_q;

endmodule
